acia_tx_sequencer: RTL

Transmit sequencer for the MOS 6551 ACIA on the SCAMP I/O bus. It initialises the ACIA control and command registers after reset, then drains a byte FIFO filled by the CPU into the ACIA transmit data register. It polls the TDRE status bit so software never busy-waits on the UART. It takes the ACIA bus through a req/gnt handshake with the bus owner and only drives ACIA strobes while granted.

---
 rtl/acia_tx_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/acia_tx_sequencer.sv
// Transmit sequencer for a 6551 ACIA: runs the register init, then drains a byte FIFO into
// the transmit data register, polling TDRE and only strobing the ACIA while the bus is granted.
module acia_tx_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [7:0]  CTRL_VAL = 8'h1E,
  parameter logic [7:0]  CMD_VAL  = 8'h0B,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic                       clk,
  input  logic                       reset_bar,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       ready,
  output logic                       bus_req,
  input  logic                       bus_gnt,
  output logic                       acia_cs,
  output logic                       acia_rw,
  output logic [1:0]                 acia_rs,
  output logic [7:0]                 acia_wdata,
  input  logic [7:0]                 acia_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    StReset,
    StInitCtl,
    StInitCmd,
    StIdle,
    StPoll,
    StWrite,
    StWait
  } state_e;

  state_e          r_state;
  logic            r_req;
  logic            r_acc;
  logic            r_rw;
  logic [1:0]      r_rs;
  logic [7:0]      r_wd;
  logic            r_ready;
  logic [GW-1:0]   r_gap;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_ovf;

  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_pop;
  logic            w_tdre;
  logic            unused_rdata;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  // full is the registered value, so a push while full is dropped even if a pop frees a slot.
  assign w_push_ok = push && !w_full;
  assign w_pop     = (r_state == StWrite) && bus_gnt;
  assign w_tdre    = acia_rdata[4];
  assign unused_rdata = ^{acia_rdata[7:5], acia_rdata[3:0]};

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (push && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Strobe values are registered per state; the grant only gates them onto the bus.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state <= StReset;
      r_req   <= 1'b0;
      r_acc   <= 1'b0;
      r_rw    <= 1'b1;
      r_rs    <= 2'b00;
      r_wd    <= 8'h00;
      r_ready <= 1'b0;
      r_gap   <= '0;
    end else begin
      unique case (r_state)
        StReset: begin
          r_state <= StInitCtl;
          r_req   <= 1'b1;
          r_acc   <= 1'b1;
          r_rw    <= 1'b0;
          r_rs    <= 2'b11;
          r_wd    <= CTRL_VAL;
        end
        StInitCtl: begin
          if (bus_gnt) begin
            r_state <= StInitCmd;
            r_rs    <= 2'b10;
            r_wd    <= CMD_VAL;
          end
        end
        StInitCmd: begin
          if (bus_gnt) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_acc   <= 1'b0;
            r_rw    <= 1'b1;
            r_rs    <= 2'b00;
            r_wd    <= 8'h00;
            r_ready <= 1'b1;
          end
        end
        StIdle: begin
          if (!w_empty) begin
            r_state <= StPoll;
            r_req   <= 1'b1;
            r_acc   <= 1'b1;
            r_rw    <= 1'b1;
            r_rs    <= 2'b01;
          end
        end
        StPoll: begin
          if (bus_gnt) begin
            if (w_tdre) begin
              r_state <= StWrite;
              r_rw    <= 1'b0;
              r_rs    <= 2'b00;
              r_wd    <= r_mem[r_rd_ptr];
            end else begin
              r_state <= StWait;
              r_req   <= 1'b0;
              r_acc   <= 1'b0;
              r_rs    <= 2'b00;
              r_gap   <= GW'(POLL_GAP - 1);
            end
          end
        end
        StWrite: begin
          if (bus_gnt) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_acc   <= 1'b0;
            r_rw    <= 1'b1;
            r_wd    <= 8'h00;
          end
        end
        StWait: begin
          if (r_gap == '0) begin
            r_state <= StPoll;
            r_req   <= 1'b1;
            r_acc   <= 1'b1;
            r_rs    <= 2'b01;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: r_state <= StReset;
      endcase
    end
  end

  always_comb begin
    acia_cs    = r_acc && bus_gnt;
    acia_rw    = acia_cs ? r_rw : 1'b1;
    acia_rs    = acia_cs ? r_rs : 2'b00;
    acia_wdata = acia_cs ? r_wd : 8'h00;
  end

  assign bus_req  = r_req;
  assign ready    = r_ready;
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_level;
  assign overflow = r_ovf;

endmodule
